// File: rtl/gate_bist_pkg.sv
// Shared types, constants and step functions for the gate-model self-test harness.
package gate_bist_pkg;

   // Stimulus/response width: pat_o[0] drives N1 ... pat_o[9] drives N10.
   localparam int WIDTH = 10;

   // Fibonacci LFSR feedback taps (x^10 + x^7 + 1): bits 9 and 6.
   localparam logic [WIDTH-1:0] LFSR_TAPS = 10'h240;

   // Galois MISR feedback polynomial (x^10 + x^3 + 1).
   localparam logic [WIDTH-1:0] MISR_POLY = 10'h009;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // One LFSR step: shift left, new LSB is the XOR of the tapped bits.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & LFSR_TAPS)};
   endfunction

   // One MISR step: Galois shift with polynomial feedback, then fold in the data word.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] fb;
      if (m[WIDTH-1]) begin
         fb = MISR_POLY;
      end else begin
         fb = {WIDTH{1'b0}};
      end
      return {m[WIDTH-2:0], 1'b0} ^ fb ^ d;
   endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Bundle of run control, stimulus/response and result signals of the self-test stage.
interface gate_bist_if;
   import gate_bist_pkg::*;

   logic             start_i;
   logic [WIDTH-1:0] pat_o;
   logic [WIDTH-1:0] resp_i;
   logic [WIDTH-1:0] golden_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] sig_o;
   logic             pass_o;

   // Harness side: starts runs, returns netlist outputs, supplies the golden signature.
   modport master (
      output start_i, resp_i, golden_i,
      input  pat_o, busy_o, done_o, sig_o, pass_o
   );

   // Self-test controller side.
   modport slave (
      input  start_i, resp_i, golden_i,
      output pat_o, busy_o, done_o, sig_o, pass_o
   );
endinterface

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register; reusable by any gate-model harness of WIDTH bits.
module gate_bist_misr import gate_bist_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] sig_o,
   output logic [WIDTH-1:0] sig_next_o
);

   logic [WIDTH-1:0] sig_d;
   logic [WIDTH-1:0] sig_q;

   // Next signature: clear wins, otherwise absorb when enabled, otherwise hold.
   always_comb begin
      sig_d = sig_q;
      if (clear_i) begin
         sig_d = {WIDTH{1'b0}};
      end else if (en_i) begin
         sig_d = misr_step(sig_q, data_i);
      end else begin
         sig_d = sig_q;
      end
   end

   // Signature register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= {WIDTH{1'b0}};
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o      = sig_q;
   assign sig_next_o = sig_d;

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test controller: LFSR stimulus into a combinational gate netlist, MISR compaction
// of its responses, and a pass/fail verdict against a golden signature.
module gate_bist_ctrl import gate_bist_pkg::*; #(
   parameter int unsigned      NPAT     = 1023,
   parameter logic [WIDTH-1:0] SEED     = 10'h001,
   parameter int unsigned      RESP_LAT = 0
) (
   input  logic       clk,
   input  logic       rst,
   gate_bist_if.slave bus
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == 10'h000) ? 10'h001 : SEED;
   localparam int               CNT_W      = $clog2(NPAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NPAT - 1);
   localparam logic [1:0]       FLUSH_LAST = 2'((RESP_LAT > 0) ? (RESP_LAT - 1) : 0);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       flush_q, flush_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic             start_ok;
   logic             in_run;
   logic             last_pat;
   logic             absorb;
   logic [WIDTH-1:0] misr_sig;
   logic [WIDTH-1:0] misr_next;

   // A start request is only honoured when no run is in progress.
   assign start_ok = bus.start_i && ((state_q == IDLE) || (state_q == DONE));
   assign in_run   = (state_q == RUN);
   assign last_pat = in_run && (cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; FLUSH drains the response pipeline and is skipped without latency.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) state_d = RUN;
            else             state_d = IDLE;
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               if (RESP_LAT == 0) state_d = DONE;
               else               state_d = FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (flush_q == FLUSH_LAST) state_d = DONE;
            else                       state_d = FLUSH;
         end
         DONE: begin
            if (bus.start_i) state_d = RUN;
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: flags follow the state being entered so they leave the flops aligned.
   always_comb begin
      busy_d = (state_d == RUN) || (state_d == FLUSH);
      done_d = (state_d == DONE);
      pass_d = pass_q;
      if (start_ok) begin
         pass_d = 1'b0;
      end else if (state_d == DONE) begin
         pass_d = (misr_next == bus.golden_i);
      end else begin
         pass_d = pass_q;
      end
   end

   // Stimulus, pattern counter and flush counter next values.
   always_comb begin
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      flush_d = 2'd0;
      if (start_ok) begin
         lfsr_d = SEED_EFF;
         cnt_d  = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            RUN: begin
               if (last_pat) begin
                  lfsr_d = lfsr_q;
                  cnt_d  = cnt_q;
               end else begin
                  lfsr_d = lfsr_step(lfsr_q);
                  cnt_d  = cnt_q + CNT_W'(1'b1);
               end
            end
            FLUSH: begin
               flush_d = flush_q + 2'd1;
            end
            DONE: begin
               lfsr_d = {WIDTH{1'b0}};
            end
            default: begin
               lfsr_d = lfsr_q;
            end
         endcase
      end
   end

   // Datapath and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         flush_q <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // The valid chain delays "pattern issued" by the netlist's register stages.
   generate
      if (RESP_LAT == 0) begin : g_no_lat
         assign absorb = in_run;
      end else begin : g_lat
         logic [RESP_LAT-1:0] vld_q, vld_d;

         // Shift the issue flag down the chain.
         always_comb begin
            vld_d    = {RESP_LAT{1'b0}};
            vld_d[0] = in_run;
            for (int i = 1; i < int'(RESP_LAT); i++) begin
               vld_d[i] = vld_q[i-1];
            end
         end

         // Valid chain register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= {RESP_LAT{1'b0}};
            end else begin
               vld_q <= vld_d;
            end
         end

         assign absorb = vld_q[RESP_LAT-1];
      end
   endgenerate

   gate_bist_misr u_misr (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (start_ok),
      .en_i       (absorb),
      .data_i     (bus.resp_i),
      .sig_o      (misr_sig),
      .sig_next_o (misr_next)
   );

   assign bus.pat_o  = lfsr_q;
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.sig_o  = misr_sig;
   assign bus.pass_o = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: several configurations side by side on one clock.
module tb_gate_bist_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   gate_bist_if if_a ();   // NPAT=10, reset mid-run
   gate_bist_if if_b ();   // NPAT=3, loopback
   gate_bist_if if_c ();   // NPAT=2, constant response
   gate_bist_if if_d ();   // NPAT=4, two-stage netlist
   gate_bist_if if_f ();   // NPAT=1023, SEED=0, stand-in gate model

   gate_bist_ctrl #(.NPAT(10),   .SEED(10'h001), .RESP_LAT(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   gate_bist_ctrl #(.NPAT(3),    .SEED(10'h001), .RESP_LAT(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   gate_bist_ctrl #(.NPAT(2),    .SEED(10'h001), .RESP_LAT(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));
   gate_bist_ctrl #(.NPAT(4),    .SEED(10'h001), .RESP_LAT(2)) u_d (.clk(clk), .rst(rst), .bus(if_d));
   gate_bist_ctrl #(.NPAT(1023), .SEED(10'h000), .RESP_LAT(0)) u_f (.clk(clk), .rst(rst), .bus(if_f));

   // Stand-in combinational gate netlist.
   function automatic logic [9:0] gm(input logic [9:0] p);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = p[i] ^ (p[(i + 1) % 10] & p[(i + 3) % 10]);
      return r;
   endfunction

   function automatic logic [9:0] ref_lfsr(input logic [9:0] p);
      return {p[8:0], p[9] ^ p[6]};
   endfunction

   function automatic logic [9:0] ref_misr(input logic [9:0] m, input logic [9:0] d);
      logic [9:0] r;
      r = m << 1;
      if (m[9]) r = r ^ 10'h009;
      return r ^ d;
   endfunction

   // Loopback, inverted data through two register stages, and the gate model.
   logic [9:0] d1 = 10'h000;
   logic [9:0] d2 = 10'h000;
   always @(posedge clk) begin
      d1 <= ~if_d.pat_o;
      d2 <= d1;
   end
   assign if_b.resp_i = if_b.pat_o;
   assign if_d.resp_i = d2;
   assign if_f.resp_i = gm(if_f.pat_o);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] lf;
      logic [9:0] ms;
      bit         seen [0:1023];
      int         distinct, zeros, perr, busy_cnt, done_at, dones;

      if_a.start_i = 1'b0; if_a.resp_i = 10'h155; if_a.golden_i = 10'h000;
      if_b.start_i = 1'b0; if_b.golden_i = 10'h000;
      if_c.start_i = 1'b0; if_c.resp_i = 10'h3FF; if_c.golden_i = 10'h000;
      if_d.start_i = 1'b0; if_d.golden_i = 10'h000;
      if_f.start_i = 1'b0; if_f.golden_i = 10'h000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check("rst_pat",  32'(if_b.pat_o),  32'h000);
      check("rst_sig",  32'(if_c.sig_o),  32'h000);
      check("rst_busy", 32'(if_b.busy_o), 32'h0);
      check("rst_done", 32'(if_d.done_o), 32'h0);
      check("rst_pass", 32'(if_f.pass_o), 32'h0);

      // Loopback, NPAT=3: signature 001 -> 000 -> 004
      if_b.golden_i = 10'h004;
      if_b.start_i = 1'b1; tick(); if_b.start_i = 1'b0;
      check("t2_pat0", 32'(if_b.pat_o), 32'h001);
      check("t2_busy", 32'(if_b.busy_o), 32'h1);
      tick(); check("t2_pat1", 32'(if_b.pat_o), 32'h002);
      tick(); check("t2_pat2", 32'(if_b.pat_o), 32'h004);
      check("t2_done_early", 32'(if_b.done_o), 32'h0);
      tick();
      check("t2_done", 32'(if_b.done_o), 32'h1);
      check("t2_sig",  32'(if_b.sig_o),  32'h004);
      check("t2_pass", 32'(if_b.pass_o), 32'h1);
      check("t2_busy_off", 32'(if_b.busy_o), 32'h0);
      tick();
      check("t2_done_pulse", 32'(if_b.done_o), 32'h0);
      check("t2_pat_idle",   32'(if_b.pat_o),  32'h000);
      check("t2_sig_hold",   32'(if_b.sig_o),  32'h004);
      check("t2_pass_hold",  32'(if_b.pass_o), 32'h1);

      // start held high: ignored while busy, honoured in DONE
      if_b.start_i = 1'b1; tick();
      check("t5_pat0", 32'(if_b.pat_o), 32'h001);
      check("t5_pass_clr", 32'(if_b.pass_o), 32'h0);
      tick(); check("t5_pat1", 32'(if_b.pat_o), 32'h002);
      tick(); tick();
      check("t5_done", 32'(if_b.done_o), 32'h1);
      tick();
      check("t5_restart_pat",  32'(if_b.pat_o),  32'h001);
      check("t5_restart_sig",  32'(if_b.sig_o),  32'h000);
      check("t5_restart_busy", 32'(if_b.busy_o), 32'h1);
      if_b.start_i = 1'b0;
      tick(); tick(); tick();
      check("t5_done2", 32'(if_b.done_o), 32'h1);
      check("t5_sig2",  32'(if_b.sig_o),  32'h004);
      tick();

      // Constant 3FF response, NPAT=2: 3FF -> 008
      if_c.golden_i = 10'h008;
      if_c.start_i = 1'b1; tick(); if_c.start_i = 1'b0;
      tick(); tick();
      check("t3_done", 32'(if_c.done_o), 32'h1);
      check("t3_sig",  32'(if_c.sig_o),  32'h008);
      check("t3_pass", 32'(if_c.pass_o), 32'h1);
      tick();
      if_c.golden_i = 10'h3F7;
      if_c.start_i = 1'b1; tick(); if_c.start_i = 1'b0;
      check("t3_sig_clr",  32'(if_c.sig_o),  32'h000);
      check("t3_pass_clr", 32'(if_c.pass_o), 32'h0);
      tick(); tick();
      check("t3_done2", 32'(if_c.done_o), 32'h1);
      check("t3_sig2",  32'(if_c.sig_o),  32'h008);
      check("t3_fail",  32'(if_c.pass_o), 32'h0);
      tick();

      // Two-stage netlist returning ~pat: 3FE -> 008 -> 3EB -> 028
      if_d.golden_i = 10'h028;
      if_d.start_i = 1'b1; tick(); if_d.start_i = 1'b0;
      busy_cnt = 0; done_at = 0;
      for (int k = 1; k <= 20; k++) begin
         if (if_d.busy_o) busy_cnt++;
         if (if_d.done_o) begin
            done_at = k;
            break;
         end
         tick();
      end
      check("t4_busy_cycles", 32'(busy_cnt), 32'd6);
      check("t4_done_at",     32'(done_at),  32'd7);
      check("t4_sig",  32'(if_d.sig_o),  32'h028);
      check("t4_pass", 32'(if_d.pass_o), 32'h1);
      tick();

      // Full-period run with zero seed and the stand-in gate model
      lf = 10'h001; ms = 10'h000;
      for (int k = 0; k < 1023; k++) begin
         ms = ref_misr(ms, gm(lf));
         lf = ref_lfsr(lf);
      end
      if_f.golden_i = ms;
      for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
      distinct = 0; zeros = 0; perr = 0;
      if_f.start_i = 1'b1; tick(); if_f.start_i = 1'b0;
      lf = 10'h001;
      for (int k = 0; k < 1023; k++) begin
         if (!seen[if_f.pat_o]) distinct++;
         seen[if_f.pat_o] = 1'b1;
         if (if_f.pat_o == 10'h000) zeros++;
         if (if_f.pat_o !== lf) perr++;
         lf = ref_lfsr(lf);
         tick();
      end
      check("t6_done",     32'(if_f.done_o), 32'h1);
      check("t6_distinct", 32'(distinct),    32'd1023);
      check("t6_zeros",    32'(zeros),       32'd0);
      check("t6_pat_seq",  32'(perr),        32'd0);
      check("t6_sig",      32'(if_f.sig_o),  32'(ms));
      check("t6_pass",     32'(if_f.pass_o), 32'h1);
      tick();

      // Async reset in cycle 5 of a 10-pattern run (sig after 4 x 155 is 018)
      if_a.start_i = 1'b1; tick(); if_a.start_i = 1'b0;
      tick(); tick(); tick(); tick();
      check("t1_pat",  32'(if_a.pat_o),  32'h010);
      check("t1_sig",  32'(if_a.sig_o),  32'h018);
      check("t1_busy", 32'(if_a.busy_o), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("t1_rst_busy", 32'(if_a.busy_o), 32'h0);
      check("t1_rst_pat",  32'(if_a.pat_o),  32'h000);
      check("t1_rst_sig",  32'(if_a.sig_o),  32'h000);
      tick();
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (if_a.done_o) dones++;
      end
      check("t1_no_done",  32'(dones),       32'd0);
      check("t1_idle_pat", 32'(if_a.pat_o),  32'h000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
